gf16_reduce_seq: RTL and testbench

//   Multi-cycle GF(2^16) modular reduction stage that sits directly downstream of the 16-bit OKA

---
 rtl/gf16_reduce_seq.sv | 94 +++++++++
 tb/tb_gf16_reduce_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gf16_reduce_seq.sv
// Sequential GF(2^16) reduction of a 31-bit carry-less product modulo x^16 + POLY.
// Folds STEP high coefficients per cycle behind valid/ready handshakes on both sides.
module gf16_reduce_seq #(
  parameter logic [15:0] POLY = 16'h002D,
  parameter int unsigned STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [30:0] in_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_res,
  output logic        busy
);

  localparam int unsigned NCYC      = (15 + STEP - 1) / STEP;
  localparam logic [30:0] POLY_FULL = {14'b0, 1'b1, POLY};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [30:0] r, r_fold;
  logic [4:0]  idx;
  logic [3:0]  cnt;

  // Chained fold of bits idx down to idx-STEP+1; bits below x^16 are left alone.
  always_comb begin
    int i;
    i      = 0;
    r_fold = r;
    for (int unsigned s = 0; s < STEP; s++) begin
      i = int'(idx) - int'(s);
      if (i >= 16) begin
        if (r_fold[i[4:0]]) r_fold = r_fold ^ (POLY_FULL << (i - 16));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = RUN;
        RUN:     if (cnt == '0) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r       <= '0;
      idx     <= '0;
      cnt     <= '0;
      out_res <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r   <= in_prod;
            idx <= 5'd30;
            cnt <= 4'(NCYC - 1);
          end
        end
        RUN: begin
          r   <= r_fold;
          idx <= idx - 5'(STEP);
          if (cnt == '0) out_res <= r_fold[15:0];
          else           cnt     <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  a_reduced: assert property (@(posedge clk) disable iff (!rst_n)
    (state == DONE) |-> (r[30:16] == '0));

endmodule

// File: tb/tb_gf16_reduce_seq.sv
// Directed and model-checked bench for gf16_reduce_seq at STEP = 1, 4 and 15.
module tb_gf16_reduce_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid  [3];
  logic [30:0] in_prod   [3];
  logic        out_ready [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        busy      [3];
  logic [15:0] out_res   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gf16_reduce_seq #(
      .POLY(16'h002D),
      .STEP((g == 0) ? 1 : ((g == 1) ? 4 : 15))
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_prod  (in_prod[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_res  (out_res[g]),
      .busy     (busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sum of x^k mod P over the set bits of p, with x^k built by repeated multiply-by-x.
  function automatic logic [15:0] ref_reduce(input logic [30:0] p);
    logic [15:0] xk, acc;
    xk  = 16'h0001;
    acc = 16'h0000;
    for (int k = 0; k < 31; k++) begin
      if (p[k]) acc = acc ^ xk;
      xk = xk[15] ? ((xk << 1) ^ 16'h002D) : (xk << 1);
    end
    return acc;
  endfunction

  task automatic run_op(input int sel, input logic [30:0] prod, input logic [15:0] exp_res,
                        input int lat, input string tag);
    int n;
    @(negedge clk);
    in_valid[sel] = 1'b1;
    in_prod[sel]  = prod;
    check({tag, "_in_ready"}, 32'(in_ready[sel]), 32'd1);
    @(posedge clk);
    #1 in_valid[sel] = 1'b0;
    n = 1;
    while (!out_valid[sel] && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_res"}, 32'(out_res[sel]), 32'(exp_res));
    @(negedge clk);
    out_ready[sel] = 1'b1;
    @(posedge clk);
    #1 out_ready[sel] = 1'b0;
    check({tag, "_released"}, {30'd0, in_ready[sel], out_valid[sel]}, 32'd2);
  endtask

  initial begin
    logic [30:0] p;
    int          seen;
    rst_n = 1'b0;
    flush = 1'b0;
    for (int g = 0; g < 3; g++) begin
      in_valid[g]  = 1'b0;
      in_prod[g]   = '0;
      out_ready[g] = 1'b0;
    end
    #12;
    check("rst_in_ready", 32'(in_ready[0]), 32'd1);
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_out_res", 32'(out_res[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 31'h4000_0000, 16'h411F, 16, "x30");
    run_op(0, 31'h0001_0000, 16'h002D, 16, "x16");
    run_op(0, 31'h0000_ABCD, 16'hABCD, 16, "low_pass");
    run_op(0, 31'h0002_0000, 16'h005A, 16, "x17");

    // Backpressure: result held for 10 cycles, new in_valid ignored.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_prod[0]  = 31'h4000_0000;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    seen = 0;
    while (!out_valid[0] && seen < 40) begin
      @(posedge clk);
      #1 seen++;
    end
    check("bp_reach_done", 32'(out_valid[0]), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_prod[0]  = 31'h0001_0000;
      @(posedge clk);
      #1;
      check("bp_res", 32'(out_res[0]), 32'h411F);
      check("bp_hold", {30'd0, in_ready[0], out_valid[0]}, 32'd1);
    end
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1 out_ready[0] = 1'b0;
    check("bp_release_idle", {30'd0, in_ready[0], busy[0]}, 32'd2);
    check("bp_res_kept", 32'(out_res[0]), 32'h411F);

    // Flush in IDLE beats in_valid.
    @(negedge clk);
    flush       = 1'b1;
    in_valid[0] = 1'b1;
    in_prod[0]  = 31'h0001_0000;
    @(posedge clk);
    #1;
    check("flush_idle_not_accepted", 32'(busy[0]), 32'd0);
    flush       = 1'b0;
    in_valid[0] = 1'b0;

    // Flush 5 cycles into RUN.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_prod[0]  = 31'h0001_0000;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_run_idle", {30'd0, busy[0], out_valid[0]}, 32'd0);
    flush = 1'b0;
    seen  = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (out_valid[0]) seen++;
    end
    check("flush_no_out_valid", 32'(seen), 32'd0);
    run_op(0, 31'h4000_0000, 16'h411F, 16, "after_flush");

    // Random products at STEP=4 and STEP=15.
    for (int k = 0; k < 1000; k++) begin
      p = 31'($urandom);
      run_op(1, p, ref_reduce(p), 5, "rand_s4");
    end
    for (int k = 0; k < 1000; k++) begin
      p = 31'($urandom);
      run_op(2, p, ref_reduce(p), 2, "rand_s15");
    end
    run_op(1, 31'h4000_0000, 16'h411F, 5, "x30_s4");
    run_op(2, 31'h7FFF_FFFF, ref_reduce(31'h7FFF_FFFF), 2, "ones_s15");

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_prod[0]  = 31'h0001_0000;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy[0]), 32'd0);
    check("arst_ready_valid", {30'd0, in_ready[0], out_valid[0]}, 32'd2);
    check("arst_out_res", 32'(out_res[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 31'h0000_1234, 16'h1234, 16, "after_arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
